// File: rtl/keypad_emulator_if.sv
// Key-code push channel for keypad_emulator.
//   key_valid : source offers key_code this cycle
//   key_code  : hex key (0x0..0xF) to press
//   key_ready : emulator queue can accept the offer
// master = key source, slave = keypad_emulator.
interface keypad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 keypad row/column scan, standing in for a PmodKYPD.
// Queued key codes are pressed one at a time for HOLD_CYCLES, released for
// GAP_CYCLES, and the active-low column return is driven for the held key
// whenever the scanner pulls that key's row low.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   key_if    : key-code push channel (valid/ready), slave side
//   JC_rows   : scanner row drive, active-low
//   JC_cols   : column return, active-low, registered
//   pressed   : a key is currently held
//   cur_key   : key being held or last held
//   key_done  : one-cycle pulse at the end of each key's release gap
//   busy      : queue non-empty or a key sequence in progress
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES = 20_000_000,
  parameter int unsigned GAP_CYCLES  = 10_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  keypad_emulator_if.slave   key_if,
  input  logic [3:0]         JC_rows,
  output logic [3:0]         JC_cols,
  output logic               pressed,
  output logic [3:0]         cur_key,
  output logic               key_done,
  output logic               busy
);

  localparam int unsigned CNT_MAX = ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) - 1;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_pop;
  logic                w_pressed_nxt;
  logic                w_done_nxt;

  logic [3:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [FCNT_W-1:0]   r_count;
  logic                w_full;
  logic                w_empty;
  logic                w_push;

  logic [3:0]          r_cur_key;
  logic                r_pressed;
  logic                r_key_done;
  logic [3:0]          r_cols;
  logic [1:0]          w_row;
  logic [1:0]          w_col;
  logic [3:0]          w_cols_nxt;

  assign w_full           = (r_count == FCNT_W'(FIFO_DEPTH));
  assign w_empty          = (r_count == '0);
  assign w_push           = key_if.key_valid && !w_full;
  assign key_if.key_ready = !w_full;

  // Key-code storage; data needs no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= key_if.key_code;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FCNT_W'(1);
        2'b01:   r_count <= r_count - FCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Press/release sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Press/release sequencer next-state and output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pop         = 1'b0;
    w_pressed_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_PRESS;
          w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      S_PRESS: begin
        w_pressed_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (r_cnt == '0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Physical position of the held key on the 4x4 matrix.
  always_comb begin
    w_row = 2'd0;
    w_col = 2'd0;
    case (r_cur_key)
      4'h1: begin w_row = 2'd0; w_col = 2'd0; end
      4'h2: begin w_row = 2'd0; w_col = 2'd1; end
      4'h3: begin w_row = 2'd0; w_col = 2'd2; end
      4'hA: begin w_row = 2'd0; w_col = 2'd3; end
      4'h4: begin w_row = 2'd1; w_col = 2'd0; end
      4'h5: begin w_row = 2'd1; w_col = 2'd1; end
      4'h6: begin w_row = 2'd1; w_col = 2'd2; end
      4'hB: begin w_row = 2'd1; w_col = 2'd3; end
      4'h7: begin w_row = 2'd2; w_col = 2'd0; end
      4'h8: begin w_row = 2'd2; w_col = 2'd1; end
      4'h9: begin w_row = 2'd2; w_col = 2'd2; end
      4'hC: begin w_row = 2'd2; w_col = 2'd3; end
      4'h0: begin w_row = 2'd3; w_col = 2'd0; end
      4'hF: begin w_row = 2'd3; w_col = 2'd1; end
      4'hE: begin w_row = 2'd3; w_col = 2'd2; end
      4'hD: begin w_row = 2'd3; w_col = 2'd3; end
      default: begin w_row = 2'd0; w_col = 2'd0; end
    endcase
  end

  // Only the held key's row is looked at, so extra low rows never alias.
  always_comb begin
    w_cols_nxt = 4'hF;
    if (r_pressed && !JC_rows[w_row]) begin
      w_cols_nxt[w_col] = 1'b0;
    end
  end

  // Registered status and column outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_key  <= 4'h0;
      r_pressed  <= 1'b0;
      r_key_done <= 1'b0;
      r_cols     <= 4'hF;
    end else begin
      if (w_pop) r_cur_key <= r_mem[r_rd_ptr];
      r_pressed  <= w_pressed_nxt;
      r_key_done <= w_done_nxt;
      r_cols     <= w_cols_nxt;
    end
  end

  assign JC_cols  = r_cols;
  assign pressed  = r_pressed;
  assign cur_key  = r_cur_key;
  assign key_done = r_key_done;
  assign busy     = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator (HOLD=4, GAP=3, depth 4).
// The reference model tracks the key queue and the cycle at which each key
// was taken, and derives every output from that timeline.
module tb_keypad_emulator;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned GAP   = 3;
  localparam int unsigned DEPTH = 4;
  localparam int KEYMAP [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] jc_rows = 4'hF;
  logic [3:0] jc_cols;
  logic       pressed;
  logic [3:0] cur_key;
  logic       key_done;
  logic       busy;

  keypad_emulator_if kbus ();

  keypad_emulator #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_if  (kbus),
    .JC_rows (jc_rows),
    .JC_cols (jc_cols),
    .pressed (pressed),
    .cur_key (cur_key),
    .key_done(key_done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  logic [3:0]  m_q [$];
  bit          m_has_pop = 1'b0;
  int unsigned m_pop_cyc = 0;
  logic [3:0]  m_cur     = 4'h0;

  logic [3:0]  e_cols    = 4'hF;
  logic        e_pressed = 1'b0;
  logic [3:0]  e_cur     = 4'h0;
  logic        e_done    = 1'b0;
  logic        e_busy    = 1'b0;
  logic        e_ready   = 1'b1;

  function automatic void locate(input logic [3:0] k, output int r, output int c);
    r = 0;
    c = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (KEYMAP[i][j] == int'(k)) begin
          r = i;
          c = j;
        end
  endfunction

  // Field order: cols, pressed, cur_key, key_done, busy, key_ready.
  function automatic logic [14:0] obs_vec();
    return {jc_cols, pressed, cur_key, key_done, busy, kbus.key_ready};
  endfunction

  function automatic logic [14:0] exp_vec();
    return {e_cols, e_pressed, e_cur, e_done, e_busy, e_ready};
  endfunction

  // Advance the reference model across one clock edge.
  task automatic model_edge(input logic v, input logic [3:0] code, input logic [3:0] rows, input logic r);
    int  ri;
    int  ci;
    bit  ready_pre;
    bit  idle;
    cyc++;
    if (r) begin
      m_q.delete();
      m_has_pop = 1'b0;
      m_cur     = 4'h0;
      e_cols    = 4'hF;
      e_pressed = 1'b0;
      e_done    = 1'b0;
    end else begin
      locate(m_cur, ri, ci);
      e_cols = 4'hF;
      if (e_pressed && rows[ri] == 1'b0) e_cols[ci] = 1'b0;
      ready_pre = (m_q.size() < DEPTH);
      idle = !m_has_pop || (cyc >= m_pop_cyc + HOLD + GAP + 1);
      if (idle && m_q.size() > 0) begin
        m_cur     = m_q.pop_front();
        m_has_pop = 1'b1;
        m_pop_cyc = cyc;
      end
      if (v && ready_pre) m_q.push_back(code);
      e_pressed = m_has_pop && (cyc >= m_pop_cyc + 1) && (cyc <= m_pop_cyc + HOLD);
      e_done    = m_has_pop && (cyc == m_pop_cyc + HOLD + GAP);
    end
    e_cur   = m_cur;
    e_busy  = (m_q.size() > 0) || (m_has_pop && (cyc + 1 <= m_pop_cyc + HOLD + GAP));
    e_ready = (m_q.size() < DEPTH);
  endtask

  task automatic step(input logic v, input logic [3:0] code, input logic [3:0] rows, input logic r);
    kbus.key_valid = v;
    kbus.key_code  = code;
    jc_rows        = rows;
    rst            = r;
    @(posedge clk);
    model_edge(v, code, rows, r);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 4'h0, 4'hF, 1'b1);
    step(1'b1, 4'h7, 4'h0, 1'b1);
    n_checks++;
    if (obs_vec() !== {4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values got=%h exp=%h", obs_vec(), {4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1});
    end
    step(1'b0, 4'h0, 4'hF, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] rows;
    for (int i = 0; i < 8; i++) begin
      rows = ~(4'b0001 << (i % 4));
      step(1'b0, 4'($urandom), rows, 1'b0);
      n_checks++;
      if (jc_cols !== 4'hF || busy !== 1'b0 || kbus.key_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_scan cyc=%0d cols=%b busy=%b rdy=%b exp cols=1111 busy=0 rdy=1",
                 cyc, jc_cols, busy, kbus.key_ready);
      end
    end
  endtask

  task automatic test_single_press();
    int n_pr = 0;
    int n_low = 0;
    int n_done = 0;
    step(1'b1, 4'h5, 4'b1101, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'($urandom), 4'b1101, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_press cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (pressed === 1'b1) n_pr++;
      if (jc_cols === 4'b1101) n_low++;
      if (key_done === 1'b1) n_done++;
    end
    n_checks++;
    if (n_pr != HOLD || n_low != HOLD || n_done != 1 || cur_key !== 4'h5) begin
      n_fail++;
      $display("FAIL single_press_totals pressed=%0d low=%0d done=%0d cur=%h exp %0d %0d 1 5",
               n_pr, n_low, n_done, cur_key, HOLD, HOLD);
    end
  endtask

  task automatic test_wrong_row();
    int n_pr = 0;
    int n_low = 0;
    step(1'b1, 4'h5, 4'b1110, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'h0, 4'b1110, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrong_row cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (pressed === 1'b1) n_pr++;
      if (jc_cols !== 4'hF) n_low++;
    end
    n_checks++;
    if (n_pr != HOLD || n_low != 0) begin
      n_fail++;
      $display("FAIL wrong_row_totals pressed=%0d notF=%0d exp %0d 0", n_pr, n_low, HOLD);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] keys [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hD};
    logic [3:0] seen [$];
    int  idx = 0;
    bit  saw_full = 1'b0;
    bit  prev_pr = 1'b0;
    bit  accept;
    for (int i = 0; i < 50; i++) begin
      accept = (idx < 5) && (kbus.key_ready === 1'b1);
      step(idx < 5, (idx < 5) ? keys[idx] : 4'h0, 4'($urandom), 1'b0);
      if (accept) idx++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (kbus.key_ready === 1'b0) saw_full = 1'b1;
      if (pressed === 1'b1 && !prev_pr) seen.push_back(cur_key);
      prev_pr = (pressed === 1'b1);
    end
    n_checks++;
    if (idx != 5 || !saw_full || seen.size() != 5) begin
      n_fail++;
      $display("FAIL back_to_back_flow accepted=%0d saw_full=%0d presses=%0d exp 5 1 5",
               idx, saw_full, seen.size());
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (k >= seen.size() || seen[k] !== keys[k]) begin
        n_fail++;
        $display("FAIL back_to_back_order slot=%0d got=%h exp=%h", k,
                 (k < seen.size()) ? seen[k] : 4'hx, keys[k]);
      end
    end
  endtask

  task automatic test_sweep();
    int n_hit = 0;
    step(1'b1, 4'hE, 4'b1110, 1'b0);
    for (int i = 1; i < 15; i++) begin
      step(1'b0, 4'h0, ~(4'b0001 << (i % 4)), 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sweep cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (jc_cols === 4'b1011) n_hit++;
    end
    n_checks++;
    if (n_hit != 1) begin
      n_fail++;
      $display("FAIL sweep_hits got=%0d exp=1", n_hit);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    step(1'b1, 4'h7, 4'b1011, 1'b0);
    step(1'b1, 4'h8, 4'b1011, 1'b0);
    step(1'b1, 4'h9, 4'b1011, 1'b0);
    step(1'b0, 4'h0, 4'b1011, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec() || jc_cols !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_mid_before got=%h exp=%h", obs_vec(), exp_vec());
    end
    step(1'b0, 4'h0, 4'b1011, 1'b1);
    n_checks++;
    if (jc_cols !== 4'hF || pressed !== 1'b0 || busy !== 1'b0 ||
        kbus.key_ready !== 1'b1 || key_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got cols=%b pr=%b busy=%b rdy=%b done=%b exp 1111 0 0 1 0",
               jc_cols, pressed, busy, kbus.key_ready, key_done);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'h0, 4'($urandom), 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (pressed !== 1'b0 || key_done !== 1'b0 || jc_cols !== 4'hF) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_flushed activity_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom), $urandom_range(0, 149) == 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    kbus.key_valid = 1'b0;
    kbus.key_code  = 4'h0;
    test_reset();
    test_idle_scan();
    test_single_press();
    test_wrong_row();
    test_back_to_back();
    test_sweep();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
